// File: rtl/add_stream_driver.sv
// Traffic source and result checker for the streaming 32-bit adder channel protocol.
// A and B issue on their own handshakes, bounded by MAX_OUT results still outstanding.
module add_stream_driver #(
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 16,
   parameter int MAX_OUT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_txn,
   input  logic [WIDTH-1:0] base_a,
   input  logic [WIDTH-1:0] base_b,
   input  logic             sink_stall,
   output logic [WIDTH-1:0] opnd__A,
   output logic             opnd__A_vld,
   input  logic             opnd__A_rdy,
   output logic [WIDTH-1:0] opnd__B,
   output logic             opnd__B_vld,
   input  logic             opnd__B_rdy,
   input  logic [WIDTH-1:0] res__C,
   input  logic             res__C_vld,
   output logic             res__C_rdy,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [WIDTH-1:0] base_a_q, base_a_d;
   logic [WIDTH-1:0] base_b_q, base_b_d;
   logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
   logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
   logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] first_err_q, first_err_d;
   logic             a_vld_q, a_vld_d;
   logic             b_vld_q, b_vld_d;
   logic [WIDTH-1:0] a_data_q, a_data_d;
   logic [WIDTH-1:0] b_data_q, b_data_d;

   logic             a_fire, b_fire, c_fire, c_rdy;
   logic [WIDTH-1:0] exp_c;

   assign c_rdy  = (state_q == RUN) & ~sink_stall & (r_cnt_q < num_q);
   assign a_fire = a_vld_q & opnd__A_rdy;
   assign b_fire = b_vld_q & opnd__B_rdy;
   assign c_fire = res__C_vld & c_rdy;
   assign exp_c  = base_a_q + base_b_q + (WIDTH'(r_cnt_q) * WIDTH'(3));

   always_comb begin
      state_d     = state_q;
      num_d       = num_q;
      base_a_d    = base_a_q;
      base_b_d    = base_b_q;
      a_cnt_d     = a_cnt_q;
      b_cnt_d     = b_cnt_q;
      r_cnt_d     = r_cnt_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               num_d       = num_txn;
               base_a_d    = base_a;
               base_b_d    = base_b;
               a_cnt_d     = '0;
               b_cnt_d     = '0;
               r_cnt_d     = '0;
               err_cnt_d   = '0;
               first_err_d = '1;
               state_d     = (num_txn == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (a_fire) a_cnt_d = a_cnt_q + 1'b1;
            if (b_fire) b_cnt_d = b_cnt_q + 1'b1;
            if (c_fire) begin
               r_cnt_d = r_cnt_q + 1'b1;
               if (res__C != exp_c) begin
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                  if (first_err_q == '1) first_err_d = r_cnt_q;
               end
            end
            if (r_cnt_q == num_q) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      // Valid is computed from next-state counters so it is a pure flop output and
      // the following operand is presented the cycle right after a transfer.
      a_vld_d  = (state_d == RUN) && (a_cnt_d < num_d) && ((a_cnt_d - r_cnt_d) < MAX_OUT_C);
      b_vld_d  = (state_d == RUN) && (b_cnt_d < num_d) && ((b_cnt_d - r_cnt_d) < MAX_OUT_C);
      a_data_d = base_a_d + WIDTH'(a_cnt_d);
      b_data_d = base_b_d + (WIDTH'(b_cnt_d) << 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         num_q       <= '0;
         base_a_q    <= '0;
         base_b_q    <= '0;
         a_cnt_q     <= '0;
         b_cnt_q     <= '0;
         r_cnt_q     <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '1;
         a_vld_q     <= 1'b0;
         b_vld_q     <= 1'b0;
         a_data_q    <= '0;
         b_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         base_a_q    <= base_a_d;
         base_b_q    <= base_b_d;
         a_cnt_q     <= a_cnt_d;
         b_cnt_q     <= b_cnt_d;
         r_cnt_q     <= r_cnt_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         a_vld_q     <= a_vld_d;
         b_vld_q     <= b_vld_d;
         a_data_q    <= a_data_d;
         b_data_q    <= b_data_d;
      end
   end

   assign opnd__A     = a_data_q;
   assign opnd__A_vld = a_vld_q;
   assign opnd__B     = b_data_q;
   assign opnd__B_vld = b_vld_q;
   assign res__C_rdy  = c_rdy;
   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign pass        = (state_q == DONE) && (err_cnt_q == '0);
   assign err_cnt     = err_cnt_q;
   assign first_err   = first_err_q;

endmodule
